// File: rtl/coeff_packer_pkg.sv
// Shared constants and helpers for the coefficient packer: bus width, fill
// counter type and the FrodoKEM coefficient widths.
package coeff_packer_pkg;

    localparam int BUS_W  = 64;
    localparam int FILL_W = 7;

    localparam int D_640  = 15;
    localparam int D_976  = 16;
    localparam int D_1344 = 16;

    typedef logic [FILL_W-1:0] fill_t;

    localparam fill_t FILL_BUS = fill_t'(BUS_W);

    // Bits removed from the accumulator by one word transfer.
    function automatic fill_t pop_amount(input fill_t f);
        return (f >= FILL_BUS) ? FILL_BUS : f;
    endfunction

endpackage

// File: rtl/coeff_packer_pack_accumulator.sv
// MSB-first bit accumulator: appends D-bit values below the current fill and
// pops 64-bit words from the top, pop applied before push in the same cycle.
module pack_accumulator
    import coeff_packer_pkg::*;
#(
    parameter int D = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [D-1:0]     din_i,
    output logic [BUS_W-1:0] top64_o,
    output fill_t            fill_o
);

    localparam int AW = BUS_W + D;

    logic [AW-1:0] acc_q, acc_d, acc_base;
    fill_t         fill_q, fill_d, fill_base;

    always_comb begin
        acc_base  = pop_i ? (acc_q << BUS_W) : acc_q;
        fill_base = pop_i ? (fill_q - pop_amount(fill_q)) : fill_q;
        acc_d     = acc_base;
        fill_d    = fill_base;
        if (push_i) begin
            // New value lands directly below the bits still held after the pop.
            acc_d  = acc_base | ({din_i, {BUS_W{1'b0}}} >> fill_base);
            fill_d = fill_base + fill_t'(D);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            fill_q <= '0;
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
        end
    end

    assign top64_o = acc_q[AW-1 -: BUS_W];
    assign fill_o  = fill_q;

endmodule

// File: rtl/coeff_packer.sv
// Packs a run of D-bit coefficients into 64-bit big-endian bitstream words
// with little-endian byte lanes; the final partial word is zero padded.
module coeff_packer
    import coeff_packer_pkg::*;
#(
    parameter int D     = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_start_i,
    input  logic [CNT_W-1:0] cmd_numCoeffs_i,
    output logic             cmd_canReceive_o,
    input  logic [D-1:0]     coeff_i,
    input  logic             coeff_isReady_i,
    output logic             coeff_canReceive_o,
    output logic [BUS_W-1:0] word_o,
    output logic             word_isReady_o,
    input  logic             word_canReceive_i,
    output logic             word_isLast_o
);

    logic [CNT_W-1:0] left_q, left_d, left_eff;
    logic [BUS_W-1:0] top64;
    fill_t            fill;
    logic             start_acc, word_avail, push, pop;

    assign cmd_canReceive_o = (left_q == '0) && (fill == '0);
    assign start_acc        = cmd_start_i & cmd_canReceive_o;

    // The count loads in the start cycle so the first coefficient can follow at once.
    assign left_eff = start_acc ? cmd_numCoeffs_i : left_q;

    assign word_avail         = (fill >= FILL_BUS) || ((left_eff == '0) && (fill != '0));
    assign word_isReady_o     = word_avail & word_canReceive_i;
    assign word_isLast_o      = word_isReady_o && (left_eff == '0) && (fill <= FILL_BUS);
    assign coeff_canReceive_o = (left_eff != '0) && ((fill < FILL_BUS) || word_isReady_o);

    assign push   = coeff_isReady_i & coeff_canReceive_o;
    assign pop    = word_isReady_o;
    assign left_d = left_eff - CNT_W'(push);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            left_q <= '0;
        end else begin
            left_q <= left_d;
        end
    end

    pack_accumulator #(
        .D (D)
    ) u_acc (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (coeff_i),
        .top64_o (top64),
        .fill_o  (fill)
    );

    // Stream byte gi (MSB-first in top64) drives output lane gi.
    for (genvar gi = 0; gi < BUS_W / 8; gi++) begin : g_lane
        assign word_o[8*gi +: 8] = top64[BUS_W-1-8*gi -: 8];
    end

endmodule

// File: tb/tb_coeff_packer.sv
// Bench for coeff_packer: D=16 and D=15 instances share stimulus, selected by sel,
// checked against a bit-list packing model.
module tb_coeff_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_start;
    logic [15:0] num;
    logic [15:0] coeff;
    logic        coeff_rdy;
    logic        word_cr;
    logic        sel;

    logic        cr16, ccr16, wr16, wl16, cr15, ccr15, wr15, wl15;
    logic [63:0] w16, w15;
    logic        cr, ccr, wr, wl;
    logic [63:0] w;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] cq[$];
    logic [63:0] exp_q[$];
    logic [63:0] got_w[$];
    logic        got_l[$];
    bit          stall_seen;
    int          held_idx;

    always #5 clk = ~clk;

    coeff_packer #(.D(16), .CNT_W(16)) u16 (
        .clk(clk), .rst(rst),
        .cmd_start_i(cmd_start & ~sel), .cmd_numCoeffs_i(num), .cmd_canReceive_o(cr16),
        .coeff_i(coeff), .coeff_isReady_i(coeff_rdy & ~sel), .coeff_canReceive_o(ccr16),
        .word_o(w16), .word_isReady_o(wr16), .word_canReceive_i(word_cr), .word_isLast_o(wl16)
    );

    coeff_packer #(.D(15), .CNT_W(16)) u15 (
        .clk(clk), .rst(rst),
        .cmd_start_i(cmd_start & sel), .cmd_numCoeffs_i(num), .cmd_canReceive_o(cr15),
        .coeff_i(coeff[14:0]), .coeff_isReady_i(coeff_rdy & sel), .coeff_canReceive_o(ccr15),
        .word_o(w15), .word_isReady_o(wr15), .word_canReceive_i(word_cr), .word_isLast_o(wl15)
    );

    assign cr  = sel ? cr15  : cr16;
    assign ccr = sel ? ccr15 : ccr16;
    assign wr  = sel ? wr15  : wr16;
    assign wl  = sel ? wl15  : wl16;
    assign w   = sel ? w15   : w16;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: concatenate coefficients MSB-first into a bit list, pad to 64,
    // stream bit k -> byte k/8, bit 7-k%8, byte j -> word[8j+7:8j].
    task automatic model_build(input int d);
        bit bits[$];
        exp_q.delete();
        foreach (cq[i])
            for (int b = d - 1; b >= 0; b--) bits.push_back(cq[i][b]);
        while (bits.size() % 64 != 0) bits.push_back(1'b0);
        for (int wi = 0; wi < bits.size() / 64; wi++) begin
            logic [63:0] v = '0;
            for (int k = 0; k < 64; k++) v[8*(k/8) + 7 - (k%8)] = bits[64*wi + k];
            exp_q.push_back(v);
        end
    endtask

    task automatic run(input bit s, input int stall_pct, input int hold, input int abort_words,
                       input bit extra_start, input string tag);
        int n, idx, cyc;
        bit done, prev_last, aborted;
        n = cq.size();
        sel = s;
        model_build(s ? 15 : 16);
        got_w.delete();
        got_l.delete();
        stall_seen = 0;
        held_idx = -1;
        idx = 0; cyc = 0; done = 0; prev_last = 0; aborted = 0;
        @(posedge clk); #1;
        cmd_start = 1'b1;
        num = 16'(n);
        while (!done && cyc < 3000) begin
            word_cr = (cyc < hold) ? 1'b0 : ($urandom_range(99) >= stall_pct);
            if (extra_start && cyc == 3) begin
                cmd_start = 1'b1;
                num = 16'd7;
            end
            #1;
            if (idx < n) begin
                if (ccr) begin
                    coeff_rdy = 1'b1;
                    coeff = cq[idx];
                    idx++;
                end else begin
                    stall_seen = 1;
                end
            end
            if (cyc == hold - 1) held_idx = idx;
            @(negedge clk);
            if (prev_last) begin
                chk({tag, ":idle_after_last"}, 64'(cr), 64'd1);
                done = 1;
            end
            if (wr) begin
                got_w.push_back(w);
                got_l.push_back(wl);
                if (wl) prev_last = 1;
                if (abort_words > 0 && got_w.size() == abort_words) begin
                    #2 rst = 1'b1;
                    #1;
                    chk({tag, ":rst_word"}, w, 64'd0);
                    chk({tag, ":rst_ready"}, 64'(wr), 64'd0);
                    chk({tag, ":rst_last"}, 64'(wl), 64'd0);
                    chk({tag, ":rst_ccr"}, 64'(ccr), 64'd0);
                    chk({tag, ":rst_cmdcr"}, 64'(cr), 64'd1);
                    done = 1;
                    aborted = 1;
                end
            end
            @(posedge clk); #1;
            cmd_start = 1'b0;
            coeff_rdy = 1'b0;
            cyc++;
        end
        word_cr = 1'b0;
        if (!done) chk({tag, ":timeout"}, 64'(cyc), 64'd0);
        if (!aborted) begin
            chk({tag, ":word_count"}, 64'(got_w.size()), 64'(exp_q.size()));
            foreach (got_w[i]) begin
                if (i < exp_q.size()) chk($sformatf("%s:word%0d", tag, i), got_w[i], exp_q[i]);
                chk($sformatf("%s:last%0d", tag, i), 64'(got_l[i]), 64'(i == exp_q.size() - 1));
            end
        end
        $display("run %s D=%0d n=%0d words=%0d", tag, s ? 15 : 16, n, got_w.size());
    endtask

    initial begin
        rst = 1'b1; cmd_start = 1'b0; num = '0; coeff = '0; coeff_rdy = 1'b0;
        word_cr = 1'b0; sel = 1'b0;
        #1;
        chk("reset16_cmdcr", 64'(cr16), 64'd1);
        chk("reset16_ccr", 64'(ccr16), 64'd0);
        chk("reset16_ready", 64'(wr16), 64'd0);
        chk("reset16_last", 64'(wl16), 64'd0);
        chk("reset16_word", w16, 64'd0);
        chk("reset15_cmdcr", 64'(cr15), 64'd1);
        chk("reset15_word", w15, 64'd0);
        #20 rst = 1'b0;

        // Single-word run
        cq = '{16'h0001, 16'h0203, 16'h0405, 16'h0607};
        run(1'b0, 0, 0, 0, 1'b0, "d16_four");
        if (got_w.size() > 0) chk("d16_four_const", got_w[0], 64'h0706050403020100);

        // 64 incrementing 15-bit coefficients, no backpressure
        cq.delete();
        for (int i = 0; i < 64; i++) cq.push_back(16'(i));
        run(1'b1, 0, 0, 0, 1'b0, "d15_incr");
        chk("d15_incr_nostall", 64'(stall_seen), 64'd0);
        chk("d15_incr_words", 64'(got_w.size()), 64'd15);

        // All-ones partial last word
        cq = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        run(1'b1, 0, 0, 0, 1'b0, "d15_ones");
        if (got_w.size() == 2) begin
            chk("d15_ones_w0", got_w[0], 64'hFFFFFFFFFFFFFFFF);
            chk("d15_ones_w1", got_w[1], 64'h000000000000E0FF);
        end

        // Downstream held off for 10 cycles
        cq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
        run(1'b0, 0, 10, 0, 1'b0, "d16_hold");
        chk("d16_hold_accepted", 64'(held_idx), 64'd4);

        // Zero-length command is a no-op
        sel = 1'b0;
        @(posedge clk); #1;
        cmd_start = 1'b1; num = 16'd0; word_cr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("zero_ready%0d", i), 64'(wr), 64'd0);
            chk($sformatf("zero_cmdcr%0d", i), 64'(cr), 64'd1);
            @(posedge clk); #1;
            cmd_start = 1'b0;
        end
        word_cr = 1'b0;
        $display("run zero_len n=0");

        // Start while busy must be ignored
        cq.delete();
        for (int i = 0; i < 12; i++) cq.push_back(16'($urandom));
        run(1'b0, 30, 0, 0, 1'b1, "d16_busy_start");

        // Asynchronous reset mid-run after three words
        cq.delete();
        for (int i = 0; i < 20; i++) cq.push_back(16'($urandom));
        run(1'b0, 0, 0, 3, 1'b0, "d16_abort");
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        cq = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718};
        run(1'b0, 0, 0, 0, 1'b0, "after_abort");

        // Randomised runs with random backpressure
        for (int r = 0; r < 20; r++) begin
            int n;
            bit s;
            s = 1'($urandom_range(1));
            n = $urandom_range(40, 1);
            cq.delete();
            for (int i = 0; i < n; i++) cq.push_back(16'($urandom));
            run(s, $urandom_range(50), 0, 0, 1'b0, $sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
